param_memory: RTL and testbench

PARAM_MEMORY -- requirements
Module: param_memory

---
 rtl/param_memory.sv | 187 ++++++++++++++++++
 tb/tb_param_memory.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/param_memory.sv
// Word-organised data memory with a fixed, parameterised access latency.
// Supports byte/half/word lanes, sign extension and a streaming preload port.
module param_memory #(
   parameter int DEPTH       = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [31:0] addr,
   input  logic [1:0]  size,
   input  logic        signExt,
   input  logic [31:0] data,
   input  logic        load_en,
   input  logic [31:0] load_data,
   output logic [31:0] dataOut,
   output logic        ready,
   output logic        err,
   output logic        busy,
   output logic        load_done
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DONE = 2'd2} state_t;

   state_t        state_r, next_state_s;
   logic [31:0]   mem_r [DEPTH];
   logic [AW-1:0] load_ptr_r;
   logic          load_done_r;
   logic [3:0]    count_r;
   logic [AW-1:0] idx_r;
   logic [1:0]    off_r;
   logic [1:0]    size_r;
   logic          sext_r;
   logic [31:0]   wdata_r;
   logic          wr_r;
   logic          rej_r;
   logic [31:0]   dataout_r;
   logic          ready_r, err_r, busy_r;
   logic          ready_nxt_s, err_nxt_s, busy_nxt_s;
   logic          load_s, accept_s, access_s, wr_en_s, rd_en_s;
   logic          unused_s;

   function automatic logic bad_align(input logic [1:0] sz, input logic [1:0] off);
      logic bad;
      case (sz)
         2'b00:   bad = 1'b0;
         2'b01:   bad = off[0];
         2'b10:   bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Only the addressed lanes are replaced; the rest of the word is preserved.
   function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] off);
      logic [31:0] res;
      res = old;
      case (sz)
         2'b00:   res[{off, 3'b000} +: 8]     = wd[7:0];
         2'b01:   res[{off[1], 4'b0000} +: 16] = wd[15:0];
         2'b10:   res = wd;
         default: res = old;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] lane_read(input logic [31:0] word, input logic [1:0] sz,
                                             input logic [1:0] off, input logic sx);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = word[{off, 3'b000} +: 8];
      h = word[{off[1], 4'b0000} +: 16];
      case (sz)
         2'b00:   res = {{24{sx & b[7]}}, b};
         2'b01:   res = {{16{sx & h[15]}}, h};
         default: res = word;
      endcase
      return res;
   endfunction

   // Load wins over a request in IDLE; preload is ignored while an access is in flight.
   assign load_s   = (state_r == ST_IDLE) & load_en;
   assign accept_s = (state_r == ST_IDLE) & ~load_en & (memRead | memWrite);
   assign access_s = (state_r == ST_WAIT) & (count_r == 4'd0);
   assign wr_en_s  = access_s & wr_r & ~rej_r;
   assign rd_en_s  = access_s & ~wr_r & ~rej_r;
   assign unused_s = ^addr[31:AW+2];

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_r <= ST_IDLE;
      else        state_r <= next_state_s;
   end

   // FSM next-state logic.
   always_comb begin
      next_state_s = ST_IDLE;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) next_state_s = ST_WAIT;
            else          next_state_s = ST_IDLE;
         end
         ST_WAIT: begin
            if (count_r == 4'd0) next_state_s = ST_DONE;
            else                 next_state_s = ST_WAIT;
         end
         ST_DONE: next_state_s = ST_IDLE;
         default: next_state_s = ST_IDLE;
      endcase
   end

   // FSM output decode, registered below so outputs track the state register.
   always_comb begin
      ready_nxt_s = 1'b0;
      err_nxt_s   = 1'b0;
      if (next_state_s == ST_DONE) begin
         ready_nxt_s = 1'b1;
         err_nxt_s   = rej_r;
      end else begin
         ready_nxt_s = 1'b0;
         err_nxt_s   = 1'b0;
      end
      busy_nxt_s = (next_state_s != ST_IDLE);
   end

   // Registered status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ready_r <= 1'b0;
         err_r   <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         ready_r <= ready_nxt_s;
         err_r   <= err_nxt_s;
         busy_r  <= busy_nxt_s;
      end
   end

   // Request capture, latency counter, preload pointer, storage and read data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= 32'h0000_0000;
         load_ptr_r  <= '0;
         load_done_r <= 1'b0;
         count_r     <= 4'd0;
         idx_r       <= '0;
         off_r       <= 2'b00;
         size_r      <= 2'b00;
         sext_r      <= 1'b0;
         wdata_r     <= 32'h0000_0000;
         wr_r        <= 1'b0;
         rej_r       <= 1'b0;
         dataout_r   <= 32'h0000_0000;
      end else begin
         load_done_r <= 1'b0;
         if (load_s) begin
            mem_r[load_ptr_r] <= load_data;
            load_ptr_r        <= load_ptr_r + AW'(1);
            load_done_r       <= (load_ptr_r == AW'(DEPTH - 1));
         end
         if (accept_s) begin
            idx_r   <= addr[AW+1:2];
            off_r   <= addr[1:0];
            size_r  <= size;
            sext_r  <= signExt;
            wdata_r <= data;
            wr_r    <= memWrite & ~memRead;
            rej_r   <= (memRead & memWrite) | bad_align(size, addr[1:0]);
            count_r <= 4'(WAIT_CYCLES);
         end else if ((state_r == ST_WAIT) && (count_r != 4'd0)) begin
            count_r <= count_r - 4'd1;
         end
         if (wr_en_s) mem_r[idx_r] <= lane_merge(mem_r[idx_r], wdata_r, size_r, off_r);
         if (rd_en_s) dataout_r <= lane_read(mem_r[idx_r], size_r, off_r, sext_r);
      end
   end

   assign dataOut   = dataout_r;
   assign ready     = ready_r;
   assign err       = err_r;
   assign busy      = busy_r;
   assign load_done = load_done_r;
endmodule

// File: tb/tb_param_memory.sv
// Scoreboard bench for param_memory (DEPTH=32, WAIT_CYCLES=2): the driver queues
// hand-computed results, a negedge monitor compares them whenever ready pulses.
module tb_param_memory;
   logic        clk = 1'b0, reset = 1'b0;
   logic        memRead = 1'b0, memWrite = 1'b0, signExt = 1'b0, load_en = 1'b0;
   logic [31:0] addr = 32'h0, data = 32'h0, load_data = 32'h0;
   logic [1:0]  size = 2'b00;
   logic [31:0] dataOut;
   logic        ready, err, busy, load_done;

   typedef struct {logic [31:0] d; logic e; string name;} exp_t;
   exp_t exp_q[$];
   exp_t cur;
   int checks = 0, failures = 0;

   param_memory #(.DEPTH(32), .WAIT_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
      .addr(addr), .size(size), .signExt(signExt), .data(data),
      .load_en(load_en), .load_data(load_data), .dataOut(dataOut),
      .ready(ready), .err(err), .busy(busy), .load_done(load_done));

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Monitor: pops an expectation on every completion pulse.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_ready actual=1 required=0");
            end else begin
               cur = exp_q.pop_front();
               check({cur.name, "_data"}, dataOut, cur.d);
               check({cur.name, "_err"}, {31'b0, err}, {31'b0, cur.e});
            end
         end else begin
            check("err_without_ready", {31'b0, err}, 32'h0);
         end
      end
   end

   task automatic access(input string nm, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [1:0] sz, input logic sx, input logic [31:0] d,
                         input logic [31:0] exp_d, input logic exp_e,
                         input logic with_load = 1'b0, input logic [31:0] ld = 32'h0);
      int n;
      int lat;
      exp_q.push_back('{exp_d, exp_e, nm});
      @(negedge clk);
      memRead = rd; memWrite = wr; addr = a; size = sz; signExt = sx; data = d;
      n = 0;
      lat = with_load ? 5 : 4;
      if (with_load) begin
         load_en = 1'b1; load_data = ld;
         @(negedge clk);
         n++;
         load_en = 1'b0;
         check({nm, "_busy_after_load"}, {31'b0, busy}, 32'h0);
      end
      do begin
         @(negedge clk);
         n++;
      end while (ready !== 1'b1 && n < 20);
      memRead = 1'b0; memWrite = 1'b0;
      check({nm, "_latency"}, n, lat);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int seen, at, n;
      repeat (2) @(negedge clk);
      check("rst_dataOut", dataOut, 32'h0);
      check("rst_ready", {31'b0, ready}, 32'h0);
      check("rst_err", {31'b0, err}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_load_done", {31'b0, load_done}, 32'h0);
      reset = 1'b1;

      // Preload word i with i*0x01010101.
      seen = 0; at = -1;
      for (int i = 0; i < 32; i++) begin
         load_en = 1'b1;
         load_data = i * 32'h0101_0101;
         @(negedge clk);
         if (load_done === 1'b1) begin seen++; at = i; end
      end
      load_en = 1'b0;
      @(negedge clk);
      if (load_done === 1'b1) seen++;
      check("load_done_count", seen, 32'd1);
      check("load_done_position", at, 32'd31);

      access("lw10",     1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0,        32'h0404_0404, 1'b0);
      access("sb11",     1'b0, 1'b1, 32'h11, 2'b00, 1'b0, 32'h0000_00AB, 32'h0404_0404, 1'b0);
      access("lw10_b",   1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0,        32'h0404_AB04, 1'b0);
      access("lb11_sx",  1'b1, 1'b0, 32'h11, 2'b00, 1'b1, 32'h0,        32'hFFFF_FFAB, 1'b0);
      access("lb11_zx",  1'b1, 1'b0, 32'h11, 2'b00, 1'b0, 32'h0,        32'h0000_00AB, 1'b0);
      access("sh12",     1'b0, 1'b1, 32'h12, 2'b01, 1'b0, 32'h0000_BEEF, 32'h0000_00AB, 1'b0);
      access("lw10_c",   1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0,        32'hBEEF_AB04, 1'b0);
      access("lh12_sx",  1'b1, 1'b0, 32'h12, 2'b01, 1'b1, 32'h0,        32'hFFFF_BEEF, 1'b0);
      access("lw06_mis", 1'b1, 1'b0, 32'h06, 2'b10, 1'b0, 32'h0,        32'hFFFF_BEEF, 1'b1);
      access("sh03_mis", 1'b0, 1'b1, 32'h03, 2'b01, 1'b0, 32'h0000_1234, 32'hFFFF_BEEF, 1'b1);
      access("lw00",     1'b1, 1'b0, 32'h00, 2'b10, 1'b0, 32'h0,        32'h0000_0000, 1'b0);
      access("rdwr04",   1'b1, 1'b1, 32'h04, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      access("lw04",     1'b1, 1'b0, 32'h04, 2'b10, 1'b0, 32'h0,        32'h0101_0101, 1'b0);
      access("sw00",     1'b0, 1'b1, 32'h00, 2'b10, 1'b0, 32'hCAFE_F00D, 32'h0101_0101, 1'b0);
      access("lw80_wrap",1'b1, 1'b0, 32'h80, 2'b10, 1'b0, 32'h0,        32'hCAFE_F00D, 1'b0);
      access("size11",   1'b1, 1'b0, 32'h0C, 2'b11, 1'b0, 32'h0,        32'hCAFE_F00D, 1'b1);
      // 33rd load overwrites word 0, then the read is accepted one edge later.
      access("load_then_lw00", 1'b1, 1'b0, 32'h00, 2'b10, 1'b0, 32'h0, 32'hA5A5_A5A5, 1'b0,
             1'b1, 32'hA5A5_A5A5);

      // Preload attempt while busy must be ignored.
      exp_q.push_back('{32'h0202_0202, 1'b0, "lw08_busy_load"});
      @(negedge clk);
      memRead = 1'b1; addr = 32'h08; size = 2'b10; signExt = 1'b0;
      @(negedge clk);
      check("busy_in_wait", {31'b0, busy}, 32'h1);
      load_en = 1'b1; load_data = 32'hDEAD_BEEF;
      @(negedge clk);
      load_en = 1'b0;
      n = 2;
      do begin
         @(negedge clk);
         n++;
      end while (ready !== 1'b1 && n < 20);
      memRead = 1'b0;
      check("lw08_busy_load_latency", n, 32'd4);
      access("lw04_untouched", 1'b1, 1'b0, 32'h04, 2'b10, 1'b0, 32'h0, 32'h0101_0101, 1'b0);
      @(negedge clk);
      load_en = 1'b1; load_data = 32'h1111_1111;
      @(negedge clk);
      load_en = 1'b0;
      access("lw04_reload", 1'b1, 1'b0, 32'h04, 2'b10, 1'b0, 32'h0, 32'h1111_1111, 1'b0);
      access("lw08_keep",   1'b1, 1'b0, 32'h08, 2'b10, 1'b0, 32'h0, 32'h0202_0202, 1'b0);

      // Reset in the middle of a write aborts it.
      @(negedge clk);
      memWrite = 1'b1; addr = 32'h20; size = 2'b10; data = 32'h1234_5678;
      @(negedge clk);
      check("busy_before_abort", {31'b0, busy}, 32'h1);
      memWrite = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("abort_busy", {31'b0, busy}, 32'h0);
      check("abort_ready", {31'b0, ready}, 32'h0);
      check("abort_dataOut", dataOut, 32'h0);
      @(negedge clk);
      check("abort_no_ready", {31'b0, ready}, 32'h0);
      reset = 1'b1;
      access("lw20_after_rst", 1'b1, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h0000_0000, 1'b0);
      access("lw10_after_rst", 1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h0000_0000, 1'b0);

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
